alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Parametrised Moore control FSM for register-to-register ALU instructions: Ri <= Ri op Rj (or Ri op P0).
//  Sits between the instruction fetch/decode FSM and the register file / ALU datapath.
//  Drives the one-hot bus enables for a configurable register count.
//  Holds off for a configurable multi-cycle ALU latency and reports completion with a done pulse.
// PARAMETERS
//  NUM_REGS  4  general registers R0..R(NUM_REGS-1); 2..16
//  IDX_W     2  register index width, must equal $clog2(NUM_REGS)
//  PARAM_W   6  width of parameter1/parameter2 fields; must be > IDX_W
//  OP_W      4  ALU opcode width
//  ALU_LAT   1  cycles alu_reg_en is held in EXEC before the result is valid; 1..15
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         asynchronous, active-high reset
//  start        in   1         request to run one ALU instruction
//  done_fetch   in   1         fetch stage has finished; parameters are stable
//  parameter1   in   PARAM_W   [IDX_W-1:0] = i (first source and destination)
//  parameter2   in   PARAM_W   [IDX_W-1:0] = j (second source); [PARAM_W-1] = 1 selects P0 instead of Rj
//  op_in        in   OP_W      ALU opcode, latched with the parameters
//  reg_in_en    out  NUM_REGS  one-hot: load register from bus
//  reg_out_en   out  NUM_REGS  one-hot: register drives bus
//  p0_out_en    out  1         P0 drives bus
//  alu_in1_en   out  1         ALU operand-1 latch enable
//  alu_in2_en   out  1         ALU operand-2 latch enable
//  alu_reg_en   out  1         ALU result register enable
//  alu_out_en   out  1         ALU result drives bus
//  alu_op       out  OP_W      latched opcode, stable from LOAD_A through DONE
//  busy         out  1         high in every state except IDLE
//  done         out  1         one-cycle completion pulse
//  err          out  1         valid only while done=1: operation aborted, no register written
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; all outputs 0 immediately, including alu_op and the latched i/j/mode.
//   - A mid-operation reset aborts the sequence with no partial write.
//  Outputs:
//   - Pure functions of state and latched fields (Moore).
//   - At most one bus driver is active in any cycle.
//  States (one per cycle unless noted):
//   - IDLE: if start=1, latch parameter1, parameter2 and op_in.
//       done_fetch=1 in the same cycle -> LOAD_A; otherwise -> WAIT_FETCH.
//   - WAIT_FETCH: stay until done_fetch=1, then -> LOAD_A. start is ignored here.
//   - LOAD_A: reg_out_en[i]=1, alu_in1_en=1 -> LOAD_B.
//   - LOAD_B: mode=0: reg_out_en[j]=1, alu_in2_en=1. mode=1: p0_out_en=1, alu_in2_en=1.
//       -> EXEC.
//   - EXEC: alu_reg_en=1 for exactly ALU_LAT cycles (down-counter loaded in LOAD_B) -> WRITE.
//   - WRITE: alu_out_en=1, reg_in_en[i]=1 -> DONE.
//   - DONE: done=1, busy=1 -> IDLE. A new start is accepted only in IDLE.
//  Latency:
//   - Counted from the accepting edge with done_fetch=1: done is high in cycle 4+ALU_LAT.
//   - Each cycle spent in WAIT_FETCH adds one.
//  Range check:
//   - i>=NUM_REGS, or (mode=0 and j>=NUM_REGS), only possible when NUM_REGS is not a power of 2.
//   - Detected in IDLE on acceptance: go straight to DONE with err=1 after WAIT_FETCH clears.
//   - No enables asserted in that case.
//  Field rules:
//   - i==j is legal: the same register is read twice.
//   - Bits of parameter1/parameter2 above IDX_W are ignored, except the mode bit [PARAM_W-1].
//   - Parameters changing after acceptance have no effect.
//  start held high continuously: a new instruction is accepted in the IDLE cycle after each DONE.
// TESTING (NUM_REGS=4, ALU_LAT=1 unless stated)
//  1. rst pulse mid-EXEC.
//     -> All outputs 0 asynchronously, state IDLE, no reg_in_en pulse.
//  2. start=1, done_fetch=1, p1=6'b000000, p2=6'b000011.
//     -> cyc1: reg_out_en=0001 + alu_in1_en.
//     -> cyc2: reg_out_en=1000 + alu_in2_en.
//     -> cyc3: alu_reg_en.
//     -> cyc4: alu_out_en + reg_in_en=0001.
//     -> cyc5: done=1, err=0.
//  3. start=1 with done_fetch=0 for 3 cycles, p1=2, p2=6'b100001.
//     -> busy, no enables during the wait; then LOAD_B drives p0_out_en (not reg_out_en).
//     -> Write to R2; done in cycle 8.
//  4. ALU_LAT=3, p1=p2=1.
//     -> reg_out_en=0010 in both LOAD cycles; alu_reg_en high exactly 3 cycles; done in cycle 7.
//  5. NUM_REGS=3, IDX_W=2, p1=3.
//     -> No enables ever asserted; done=1 and err=1 in cycle 1.
//  6. start held high across two instructions; start pulsed during EXEC.
//     -> Second instruction begins only after DONE->IDLE; the mid-EXEC pulse is ignored.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Moore control FSM for register-to-register ALU instructions: Ri <= Ri op Rj,
// or Ri <= Ri op P0 when the mode bit of parameter2 is set. It sits between the
// fetch/decode FSM and the register-file / ALU datapath. It sequences the bus
// enables as follows:
//   LOAD_A -> LOAD_B -> EXEC (ALU_LAT cycles) -> WRITE -> DONE.
// An out-of-range register index skips straight to DONE with err set, and no
// enables are asserted in that case.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request to run one instruction (sampled in IDLE only)
//   done_fetch   fetch stage finished, parameters stable
//   parameter1   [IDX_W-1:0] = i, first source and destination
//   parameter2   [IDX_W-1:0] = j, second source; [PARAM_W-1] selects P0
//   op_in        ALU opcode, latched with the parameters
//   reg_in_en    one-hot register load-from-bus enable
//   reg_out_en   one-hot register drive-bus enable
//   p0_out_en    P0 drives bus
//   alu_in1_en   ALU operand-1 latch enable
//   alu_in2_en   ALU operand-2 latch enable
//   alu_reg_en   ALU result register enable
//   alu_out_en   ALU result drives bus
//   alu_op       latched opcode
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   err          qualified by done: instruction aborted, nothing written

module alu_op_sequencer #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned PARAM_W  = 6,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned ALU_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                done_fetch,
  input  logic [PARAM_W-1:0]  parameter1,
  input  logic [PARAM_W-1:0]  parameter2,
  input  logic [OP_W-1:0]     op_in,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic                p0_out_en,
  output logic                alu_in1_en,
  output logic                alu_in2_en,
  output logic                alu_reg_en,
  output logic                alu_out_en,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFetch,
    StLoadA,
    StLoadB,
    StExec,
    StWrite,
    StDone
  } state_t;

  // EXEC runs while the counter counts down to zero, so it is loaded with ALU_LAT-1.
  localparam logic [3:0]     LatInit   = 4'(ALU_LAT - 1);
  localparam int unsigned    NumRegsI  = NUM_REGS;
  localparam logic [IDX_W:0] NumRegsW  = NumRegsI[IDX_W:0];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  i_q, j_q;
  logic              mode_q;
  logic              err_q;
  logic [OP_W-1:0]   op_q;
  logic [3:0]        cnt_q;

  logic [IDX_W-1:0]  i_in, j_in;
  logic              mode_in;
  logic              range_bad;
  logic              accept;
  logic [NUM_REGS-1:0] i_hot, j_hot;

  assign i_in    = parameter1[IDX_W-1:0];
  assign j_in    = parameter2[IDX_W-1:0];
  assign mode_in = parameter2[PARAM_W-1];

  // Index bits above IDX_W carry no meaning (apart from the mode bit).
  if (PARAM_W > IDX_W + 1) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{parameter1[PARAM_W-1:IDX_W], parameter2[PARAM_W-2:IDX_W]};
  end else begin : g_unused_p1
    logic unused_hi;
    assign unused_hi = ^parameter1[PARAM_W-1:IDX_W];
  end

  // Only reachable when NUM_REGS is not a power of two; j is irrelevant in P0 mode.
  assign range_bad = ({1'b0, i_in} >= NumRegsW) ||
                     (!mode_in && ({1'b0, j_in} >= NumRegsW));

  assign accept = (state_q == StIdle) && start;

  always_comb begin
    i_hot = '0;
    j_hot = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      i_hot[k] = (i_q == k[IDX_W-1:0]);
      j_hot[k] = (j_q == k[IDX_W-1:0]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (done_fetch) begin
            state_d = range_bad ? StDone : StLoadA;
          end else begin
            state_d = StWaitFetch;
          end
        end
      end
      StWaitFetch: begin
        if (done_fetch) begin
          state_d = err_q ? StDone : StLoadA;
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StExec;
      StExec: begin
        if (cnt_q == '0) begin
          state_d = StWrite;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Instruction fields are captured once, on acceptance, and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
      op_q   <= '0;
    end else if (accept) begin
      i_q    <= i_in;
      j_q    <= j_in;
      mode_q <= mode_in;
      err_q  <= range_bad;
      op_q   <= op_in;
    end
  end

  // ALU latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StLoadB) begin
      cnt_q <= LatInit;
    end else if ((state_q == StExec) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Moore outputs
  always_comb begin
    reg_in_en  = '0;
    reg_out_en = '0;
    p0_out_en  = 1'b0;
    alu_in1_en = 1'b0;
    alu_in2_en = 1'b0;
    alu_reg_en = 1'b0;
    alu_out_en = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StLoadA: begin
        reg_out_en = i_hot;
        alu_in1_en = 1'b1;
      end
      StLoadB: begin
        if (mode_q) begin
          p0_out_en = 1'b1;
        end else begin
          reg_out_en = j_hot;
        end
        alu_in2_en = 1'b1;
      end
      StExec: begin
        alu_reg_en = 1'b1;
      end
      StWrite: begin
        alu_out_en = 1'b1;
        reg_in_en  = i_hot;
      end
      StDone: begin
        done = 1'b1;
        err  = err_q;
      end
      default: begin
      end
    endcase
  end

  assign alu_op = op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. Three instances share clock, reset,
// done_fetch and the parameter buses:
//   dut_a: NUM_REGS=4, ALU_LAT=1
//   dut_b: NUM_REGS=4, ALU_LAT=3
//   dut_c: NUM_REGS=3, ALU_LAT=1
// Each instance has its own start signal.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Cycle n is the n-th cycle after the accepting rising edge.
// Output vectors are packed in this order:
//   {reg_in_en, reg_out_en, p0, in1, in2, alu_reg, alu_out, busy, done, err}

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, start_c;
  logic       done_fetch;
  logic [5:0] p1, p2;
  logic [3:0] op_in;

  logic [3:0] rin_a, rout_a, rin_b, rout_b;
  logic [2:0] rin_c, rout_c;
  logic       p0_a, in1_a, in2_a, areg_a, aout_a, busy_a, done_a, err_a;
  logic       p0_b, in1_b, in2_b, areg_b, aout_b, busy_b, done_b, err_b;
  logic       p0_c, in1_c, in2_c, areg_c, aout_c, busy_c, done_c, err_c;
  logic [3:0] op_a, op_b, op_c;

  logic [15:0] obs_a, obs_b;
  logic [13:0] obs_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs_a = {rin_a, rout_a, p0_a, in1_a, in2_a, areg_a, aout_a, busy_a, done_a, err_a};
  assign obs_b = {rin_b, rout_b, p0_b, in1_b, in2_b, areg_b, aout_b, busy_b, done_b, err_b};
  assign obs_c = {rin_c, rout_c, p0_c, in1_c, in2_c, areg_c, aout_c, busy_c, done_c, err_c};

  alu_op_sequencer #(
    .NUM_REGS(4), .IDX_W(2), .PARAM_W(6), .OP_W(4), .ALU_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .done_fetch(done_fetch),
    .parameter1(p1), .parameter2(p2), .op_in(op_in),
    .reg_in_en(rin_a), .reg_out_en(rout_a), .p0_out_en(p0_a),
    .alu_in1_en(in1_a), .alu_in2_en(in2_a), .alu_reg_en(areg_a), .alu_out_en(aout_a),
    .alu_op(op_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  alu_op_sequencer #(
    .NUM_REGS(4), .IDX_W(2), .PARAM_W(6), .OP_W(4), .ALU_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done_fetch(done_fetch),
    .parameter1(p1), .parameter2(p2), .op_in(op_in),
    .reg_in_en(rin_b), .reg_out_en(rout_b), .p0_out_en(p0_b),
    .alu_in1_en(in1_b), .alu_in2_en(in2_b), .alu_reg_en(areg_b), .alu_out_en(aout_b),
    .alu_op(op_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  alu_op_sequencer #(
    .NUM_REGS(3), .IDX_W(2), .PARAM_W(6), .OP_W(4), .ALU_LAT(1)
  ) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .done_fetch(done_fetch),
    .parameter1(p1), .parameter2(p2), .op_in(op_in),
    .reg_in_en(rin_c), .reg_out_en(rout_c), .p0_out_en(p0_c),
    .alu_in1_en(in1_c), .alu_in2_en(in2_c), .alu_reg_en(areg_c), .alu_out_en(aout_c),
    .alu_op(op_c), .busy(busy_c), .done(done_c), .err(err_c)
  );

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    done_fetch = 1'b0; p1 = '0; p2 = '0; op_in = '0;
    #2;
    checks++;
    if (obs_a !== 16'h0 || op_a !== 4'h0) begin
      errors++;
      $display("FAIL reset_a got %b op %h want 0 op 0", obs_a, op_a);
    end
    checks++;
    if (obs_b !== 16'h0 || obs_c !== 14'h0) begin
      errors++;
      $display("FAIL reset_bc got %b %b want all zero", obs_b, obs_c);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Spec scenario 2, plus parameter changes after acceptance must be ignored.
  task automatic test_basic();
    logic [15:0] want [6] = '{
      16'b0000_0001_0_1_0_0_0_1_0_0,
      16'b0000_1000_0_0_1_0_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0001_0000_0_0_0_0_1_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_1_0,
      16'b0000_0000_0_0_0_0_0_0_0_0
    };
    p1 = 6'b000000; p2 = 6'b000011; op_in = 4'h5; done_fetch = 1'b1; start_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== want[c-1]) begin
        errors++;
        $display("FAIL basic cyc %0d got %b want %b", c, obs_a, want[c-1]);
      end
      if (c == 1) begin
        checks++;
        if (op_a !== 4'h5) begin
          errors++;
          $display("FAIL basic_op got %h want 5", op_a);
        end
        start_a = 1'b0; p1 = 6'b000010; p2 = 6'b100001; op_in = 4'hf;
      end
      if (c == 5) begin
        checks++;
        if (op_a !== 4'h5) begin
          errors++;
          $display("FAIL basic_op_held got %h want 5", op_a);
        end
      end
    end
  endtask

  // Spec scenario 1: async reset while in EXEC.
  task automatic test_reset_mid_exec();
    p1 = 6'd1; p2 = 6'd2; op_in = 4'ha; done_fetch = 1'b1; start_a = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start_a = 1'b0;
    end
    checks++;
    if (obs_a !== 16'b0000_0000_0_0_0_1_0_1_0_0) begin
      errors++;
      $display("FAIL rst_pre_exec got %b want 0000000000010100", obs_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== 16'h0 || op_a !== 4'h0) begin
      errors++;
      $display("FAIL rst_async got %b op %h want 0 op 0", obs_a, op_a);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== 16'h0) begin
        errors++;
        $display("FAIL rst_after cyc %0d got %b want 0", c, obs_a);
      end
    end
  endtask

  // Spec scenario 3: three WAIT_FETCH cycles, P0 mode, upper p1 bits ignored.
  task automatic test_fetch_wait();
    logic [15:0] want [9] = '{
      16'b0000_0000_0_0_0_0_0_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_0_0,
      16'b0000_0100_0_1_0_0_0_1_0_0,
      16'b0000_0000_1_0_1_0_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0100_0000_0_0_0_0_1_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_1_0,
      16'b0000_0000_0_0_0_0_0_0_0_0
    };
    p1 = 6'b111110; p2 = 6'b100001; op_in = 4'h7; done_fetch = 1'b0; start_a = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== want[c-1]) begin
        errors++;
        $display("FAIL fetch_wait cyc %0d got %b want %b", c, obs_a, want[c-1]);
      end
      if (c == 1) start_a = 1'b0;
      if (c == 2) begin
        start_a = 1'b1;  // ignored in WAIT_FETCH
        p1 = 6'b000001;
      end
      if (c == 3) begin
        start_a = 1'b0;
        done_fetch = 1'b1;
      end
    end
  endtask

  // Spec scenario 4: ALU_LAT=3, i==j.
  task automatic test_long_latency();
    logic [15:0] want [8] = '{
      16'b0000_0010_0_1_0_0_0_1_0_0,
      16'b0000_0010_0_0_1_0_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0010_0000_0_0_0_0_1_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_1_0,
      16'b0000_0000_0_0_0_0_0_0_0_0
    };
    p1 = 6'd1; p2 = 6'd1; op_in = 4'h2; done_fetch = 1'b1; start_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (obs_b !== want[c-1]) begin
        errors++;
        $display("FAIL long_lat cyc %0d got %b want %b", c, obs_b, want[c-1]);
      end
      if (c == 1) start_b = 1'b0;
    end
  endtask

  // Spec scenario 5 on NUM_REGS=3, plus the j check and the P0-mode exemption.
  task automatic test_range();
    logic [13:0] want_c [6] = '{
      14'b000_100_0_1_0_0_0_1_0_0,
      14'b000_000_1_0_1_0_0_1_0_0,
      14'b000_000_0_0_0_1_0_1_0_0,
      14'b100_000_0_0_0_0_1_1_0_0,
      14'b000_000_0_0_0_0_0_1_1_0,
      14'b000_000_0_0_0_0_0_0_0_0
    };
    // i = 3 (upper bits set and ignored), fetch already done.
    p1 = 6'b111011; p2 = 6'd0; done_fetch = 1'b1; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    checks++;
    if (obs_c !== 14'b000_000_0_0_0_0_0_1_1_1) begin
      errors++;
      $display("FAIL range_i got %b want 00000000000111", obs_c);
    end
    @(negedge clk);
    checks++;
    if (obs_c !== 14'h0) begin
      errors++;
      $display("FAIL range_i_idle got %b want 0", obs_c);
    end
    // j = 3 in register mode, one WAIT_FETCH cycle first.
    p1 = 6'd0; p2 = 6'd3; done_fetch = 1'b0; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0; done_fetch = 1'b1;
    checks++;
    if (obs_c !== 14'b000_000_0_0_0_0_0_1_0_0) begin
      errors++;
      $display("FAIL range_j_wait got %b want 00000000000100", obs_c);
    end
    @(negedge clk);
    checks++;
    if (obs_c !== 14'b000_000_0_0_0_0_0_1_1_1) begin
      errors++;
      $display("FAIL range_j got %b want 00000000000111", obs_c);
    end
    @(negedge clk);
    checks++;
    if (obs_c !== 14'h0) begin
      errors++;
      $display("FAIL range_j_idle got %b want 0", obs_c);
    end
    // j = 3 but P0 mode: legal.
    p1 = 6'd2; p2 = 6'b100011; start_c = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (obs_c !== want_c[c-1]) begin
        errors++;
        $display("FAIL range_p0 cyc %0d got %b want %b", c, obs_c, want_c[c-1]);
      end
      if (c == 1) start_c = 1'b0;
    end
  endtask

  // Spec scenario 6a: start held high across two instructions.
  task automatic test_back_to_back();
    logic [15:0] want [13] = '{
      16'b0000_0001_0_1_0_0_0_1_0_0,
      16'b0000_0010_0_0_1_0_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0001_0000_0_0_0_0_1_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_1_0,
      16'b0000_0000_0_0_0_0_0_0_0_0,
      16'b0000_1000_0_1_0_0_0_1_0_0,
      16'b0000_0100_0_0_1_0_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b1000_0000_0_0_0_0_1_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_1_0,
      16'b0000_0000_0_0_0_0_0_0_0_0,
      16'b0000_0000_0_0_0_0_0_0_0_0
    };
    p1 = 6'd0; p2 = 6'd1; op_in = 4'h3; done_fetch = 1'b1; start_a = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== want[c-1]) begin
        errors++;
        $display("FAIL b2b cyc %0d got %b want %b", c, obs_a, want[c-1]);
      end
      if (c == 1) begin
        checks++;
        if (op_a !== 4'h3) begin
          errors++;
          $display("FAIL b2b_op1 got %h want 3", op_a);
        end
      end
      if (c == 7) begin
        checks++;
        if (op_a !== 4'h9) begin
          errors++;
          $display("FAIL b2b_op2 got %h want 9", op_a);
        end
      end
      if (c == 3) begin
        p1 = 6'd3; p2 = 6'd2; op_in = 4'h9;
      end
      if (c == 10) start_a = 1'b0;
    end
  endtask

  // Spec scenario 6b: a start pulse during EXEC is ignored.
  task automatic test_start_pulse_exec();
    logic [15:0] want [7] = '{
      16'b0000_0010_0_1_0_0_0_1_0_0,
      16'b0000_0000_1_0_1_0_0_1_0_0,
      16'b0000_0000_0_0_0_1_0_1_0_0,
      16'b0010_0000_0_0_0_0_1_1_0_0,
      16'b0000_0000_0_0_0_0_0_1_1_0,
      16'b0000_0000_0_0_0_0_0_0_0_0,
      16'b0000_0000_0_0_0_0_0_0_0_0
    };
    p1 = 6'd1; p2 = 6'b100000; op_in = 4'h4; done_fetch = 1'b1; start_a = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== want[c-1]) begin
        errors++;
        $display("FAIL pulse_exec cyc %0d got %b want %b", c, obs_a, want[c-1]);
      end
      if (c == 1) start_a = 1'b0;
      if (c == 3) start_a = 1'b1;
      if (c == 4) start_a = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_exec();
    test_fetch_wait();
    test_long_latency();
    test_range();
    test_back_to_back();
    test_start_pulse_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
